// File: rtl/nvme_sched_pkg.sv
// Shared types for the NVMe submission-queue fetch scheduler: FSM states,
// entry geometry and the per-queue context record.
package nvme_sched_pkg;

   localparam int ENTRY_SHIFT = 6;
   localparam int SQ_ADDR_W   = 64;
   localparam int SQ_PTR_W    = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      UPDATE = 2'd3
   } fsm_state_e;

   typedef struct packed {
      logic [SQ_ADDR_W-1:0] base;
      logic [SQ_PTR_W-1:0]  depth;
      logic [SQ_PTR_W-1:0]  head;
      logic [SQ_PTR_W-1:0]  tail;
      logic                 en;
      logic                 err;
   } sq_ctx_t;

endpackage

// File: rtl/nvme_sq_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// rr_ptr, wrapping around, wins.
module rr_arbiter #(
   parameter int NUM_Q = 4,
   parameter int QID_W = $clog2(NUM_Q)
) (
   input  logic [NUM_Q-1:0] req,
   input  logic [QID_W-1:0] rr_ptr,
   output logic [NUM_Q-1:0] gnt_oh,
   output logic [QID_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   logic [QID_W-1:0] idx;

   // Scan from the farthest offset down so the nearest request to rr_ptr is written last.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      idx     = '0;
      for (int i = NUM_Q - 1; i >= 0; i--) begin
         idx = rr_ptr + QID_W'(i);
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
      gnt_oh[gnt_idx] = gnt_vld;
   end

endmodule

// File: rtl/nvme_sq_fetch_scheduler.sv
// Round-robin command-fetch scheduler sharing one AXI master among NUM_Q
// NVMe submission queues; one 64-byte entry fetch in flight at a time.
module nvme_sq_fetch_scheduler #(
   parameter int NUM_Q       = 4,
   parameter int QID_W       = $clog2(NUM_Q),
   parameter int PTR_W       = 16,
   parameter int ADDR_W      = 64,
   parameter int ENTRY_SHIFT = 6
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              cfg_we,
   input  logic [QID_W-1:0]  cfg_qid,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [PTR_W-1:0]  cfg_depth,
   input  logic              cfg_en,
   output logic              cfg_err,
   input  logic              db_valid,
   input  logic [QID_W-1:0]  db_qid,
   input  logic [PTR_W-1:0]  db_tail,
   output logic              fetch_init,
   output logic [ADDR_W-1:0] fetch_addr,
   output logic [QID_W-1:0]  fetch_qid,
   input  logic              fetch_done,
   input  logic              fetch_error,
   output logic              head_upd,
   output logic [QID_W-1:0]  head_qid,
   output logic [PTR_W-1:0]  head_val,
   output logic [NUM_Q-1:0]  q_err,
   output logic              busy
);

   import nvme_sched_pkg::*;

   sq_ctx_t              ctx [NUM_Q];
   fsm_state_e           state;
   logic [QID_W-1:0]     rr_ptr;
   logic [NUM_Q-1:0]     pending;
   logic [NUM_Q-1:0]     gnt_oh;
   logic [QID_W-1:0]     gnt_idx;
   logic                 gnt_vld;
   logic                 cfg_block;
   logic [SQ_PTR_W-1:0]  head_nxt;
   logic [SQ_ADDR_W-1:0] sel_base;
   logic [SQ_PTR_W-1:0]  sel_head;

   always_comb begin
      pending  = '0;
      q_err    = '0;
      sel_base = '0;
      sel_head = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         pending[q] = ctx[q].en && !ctx[q].err && (ctx[q].head != ctx[q].tail);
         q_err[q]   = ctx[q].err;
         if (gnt_oh[q]) begin
            sel_base = sel_base | ctx[q].base;
            sel_head = sel_head | ctx[q].head;
         end
      end
   end

   rr_arbiter #(
      .NUM_Q (NUM_Q),
      .QID_W (QID_W)
   ) u_arb (
      .req     (pending),
      .rr_ptr  (rr_ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // The in-flight queue's context must not change under the outstanding fetch.
   assign cfg_block = ((state == ISSUE) || (state == WAIT)) && (cfg_qid == fetch_qid);
   assign head_nxt  = (ctx[fetch_qid].head == ctx[fetch_qid].depth) ? '0
                    : ctx[fetch_qid].head + SQ_PTR_W'(1);
   assign busy      = (state != IDLE);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int q = 0; q < NUM_Q; q++) begin
            ctx[q] <= '0;
         end
      end else begin
         for (int q = 0; q < NUM_Q; q++) begin
            if (cfg_we && !cfg_block && (cfg_qid == QID_W'(q))) begin
               ctx[q].base  <= SQ_ADDR_W'(cfg_base);
               ctx[q].depth <= SQ_PTR_W'(cfg_depth);
               ctx[q].en    <= cfg_en;
               ctx[q].head  <= '0;
               ctx[q].tail  <= '0;
               ctx[q].err   <= 1'b0;
            end else begin
               if (db_valid && (db_qid == QID_W'(q))) begin
                  if (SQ_PTR_W'(db_tail) > ctx[q].depth) begin
                     ctx[q].err <= 1'b1;
                  end else begin
                     ctx[q].tail <= SQ_PTR_W'(db_tail);
                  end
               end
               if ((state == WAIT) && fetch_done && (fetch_qid == QID_W'(q))) begin
                  if (fetch_error) begin
                     ctx[q].err <= 1'b1;
                  end else begin
                     ctx[q].head <= head_nxt;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         fetch_init <= 1'b0;
         fetch_addr <= '0;
         fetch_qid  <= '0;
         head_upd   <= 1'b0;
         head_qid   <= '0;
         head_val   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_err    <= cfg_we && cfg_block;
         fetch_init <= 1'b0;
         head_upd   <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  fetch_qid  <= gnt_idx;
                  fetch_addr <= ADDR_W'(sel_base) + (ADDR_W'(sel_head) << ENTRY_SHIFT);
                  fetch_init <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (fetch_done) begin
                  if (!fetch_error) begin
                     head_upd <= 1'b1;
                     head_qid <= fetch_qid;
                     head_val <= PTR_W'(head_nxt);
                  end
                  rr_ptr <= fetch_qid + QID_W'(1);
                  state  <= UPDATE;
               end
            end
            // Gives the head write one cycle to land before the next arbitration.
            UPDATE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nvme_sq_fetch_scheduler.sv
// Directed bench for nvme_sq_fetch_scheduler: fetch sequencing, round robin,
// head wrap, error handling, config rejection and asynchronous reset.
module tb_nvme_sq_fetch_scheduler;

   logic        clk = 1'b0;
   logic        ARESETN;
   logic        cfg_we;
   logic [1:0]  cfg_qid;
   logic [63:0] cfg_base;
   logic [15:0] cfg_depth;
   logic        cfg_en;
   logic        cfg_err;
   logic        db_valid;
   logic [1:0]  db_qid;
   logic [15:0] db_tail;
   logic        fetch_init;
   logic [63:0] fetch_addr;
   logic [1:0]  fetch_qid;
   logic        fetch_done;
   logic        fetch_error;
   logic        head_upd;
   logic [1:0]  head_qid;
   logic [15:0] head_val;
   logic [3:0]  q_err;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   int last_gap    = 0;

   always #5 clk = ~clk;

   nvme_sq_fetch_scheduler dut (
      .ACLK        (clk),
      .ARESETN     (ARESETN),
      .cfg_we      (cfg_we),
      .cfg_qid     (cfg_qid),
      .cfg_base    (cfg_base),
      .cfg_depth   (cfg_depth),
      .cfg_en      (cfg_en),
      .cfg_err     (cfg_err),
      .db_valid    (db_valid),
      .db_qid      (db_qid),
      .db_tail     (db_tail),
      .fetch_init  (fetch_init),
      .fetch_addr  (fetch_addr),
      .fetch_qid   (fetch_qid),
      .fetch_done  (fetch_done),
      .fetch_error (fetch_error),
      .head_upd    (head_upd),
      .head_qid    (head_qid),
      .head_val    (head_val),
      .q_err       (q_err),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] q, input logic [63:0] base, input logic [15:0] depth,
                      input logic en);
      cfg_we = 1'b1; cfg_qid = q; cfg_base = base; cfg_depth = depth; cfg_en = en;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic db(input logic [1:0] q, input logic [15:0] tail);
      db_valid = 1'b1; db_qid = q; db_tail = tail;
      @(negedge clk);
      db_valid = 1'b0;
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (fetch_init !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      last_gap = n;
      check({tag, "_init"}, {63'd0, fetch_init}, 64'd1);
   endtask

   task automatic finish_fetch(input string tag, input logic [1:0] qid, input logic [63:0] addr,
                               input logic err, input logic [15:0] hval);
      check({tag, "_qid"}, {62'd0, fetch_qid}, {62'd0, qid});
      check({tag, "_addr"}, fetch_addr, addr);
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      @(negedge clk);
      fetch_done = 1'b1; fetch_error = err;
      @(negedge clk);
      fetch_done = 1'b0; fetch_error = 1'b0;
      if (err) begin
         check({tag, "_noupd"}, {63'd0, head_upd}, 64'd0);
      end else begin
         check({tag, "_upd"}, {63'd0, head_upd}, 64'd1);
         check({tag, "_hqid"}, {62'd0, head_qid}, {62'd0, qid});
         check({tag, "_hval"}, {48'd0, head_val}, {48'd0, hval});
      end
   endtask

   initial begin
      int seen;
      ARESETN = 1'b0;
      cfg_we = 1'b0; cfg_qid = '0; cfg_base = '0; cfg_depth = '0; cfg_en = 1'b0;
      db_valid = 1'b0; db_qid = '0; db_tail = '0;
      fetch_done = 1'b0; fetch_error = 1'b0;

      @(negedge clk);
      check("rst_init", {63'd0, fetch_init}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_qerr", {60'd0, q_err}, 64'd0);
      check("rst_addr", fetch_addr, 64'd0);
      check("rst_hupd", {63'd0, head_upd}, 64'd0);
      ARESETN = 1'b1;
      @(negedge clk);

      // Basic fetch, latency and back-to-back spacing
      cfg(2'd0, 64'h1000, 16'd7, 1'b1);
      db(2'd0, 16'd3);
      check("t1_lat0", {63'd0, fetch_init}, 64'd0);
      @(negedge clk);
      check("t1_lat1", {63'd0, fetch_init}, 64'd1);
      wait_init("t1a");
      finish_fetch("t1a", 2'd0, 64'h1000, 1'b0, 16'd1);
      wait_init("t1b");
      check("t1_gap", 64'(last_gap), 64'd2);
      finish_fetch("t1b", 2'd0, 64'h1040, 1'b0, 16'd2);
      wait_init("t1c");
      finish_fetch("t1c", 2'd0, 64'h1080, 1'b0, 16'd3);
      repeat (3) @(negedge clk);
      check("t1_idle", {63'd0, busy}, 64'd0);

      // Round robin across four queues
      cfg(2'd0, 64'h1000, 16'd7, 1'b1);
      cfg(2'd1, 64'h2000, 16'd7, 1'b1);
      cfg(2'd2, 64'h3000, 16'd7, 1'b1);
      cfg(2'd3, 64'h4000, 16'd7, 1'b1);
      db(2'd0, 16'd2);
      db(2'd1, 16'd2);
      db(2'd2, 16'd2);
      db(2'd3, 16'd2);
      finish_fetch("t2_0", 2'd0, 64'h1000, 1'b0, 16'd1);
      wait_init("t2_1"); finish_fetch("t2_1", 2'd1, 64'h2000, 1'b0, 16'd1);
      wait_init("t2_2"); finish_fetch("t2_2", 2'd2, 64'h3000, 1'b0, 16'd1);
      wait_init("t2_3"); finish_fetch("t2_3", 2'd3, 64'h4000, 1'b0, 16'd1);
      wait_init("t2_4"); finish_fetch("t2_4", 2'd0, 64'h1040, 1'b0, 16'd2);
      wait_init("t2_5"); finish_fetch("t2_5", 2'd1, 64'h2040, 1'b0, 16'd2);
      wait_init("t2_6"); finish_fetch("t2_6", 2'd2, 64'h3040, 1'b0, 16'd2);
      wait_init("t2_7"); finish_fetch("t2_7", 2'd3, 64'h4040, 1'b0, 16'd2);

      // Head wrap at depth 3
      cfg(2'd2, 64'h3000, 16'd3, 1'b1);
      db(2'd2, 16'd3);
      wait_init("t3a"); finish_fetch("t3a", 2'd2, 64'h3000, 1'b0, 16'd1);
      wait_init("t3b"); finish_fetch("t3b", 2'd2, 64'h3040, 1'b0, 16'd2);
      wait_init("t3c"); finish_fetch("t3c", 2'd2, 64'h3080, 1'b0, 16'd3);
      db(2'd2, 16'd1);
      wait_init("t3d"); finish_fetch("t3d", 2'd2, 64'h30C0, 1'b0, 16'd0);
      wait_init("t3e"); finish_fetch("t3e", 2'd2, 64'h3000, 1'b0, 16'd1);

      // Fetch error, queue skipped, cleared by config
      cfg(2'd1, 64'h2000, 16'd7, 1'b1);
      db(2'd1, 16'd2);
      wait_init("t4a"); finish_fetch("t4a", 2'd1, 64'h2000, 1'b1, 16'd0);
      check("t4_qerr", {60'd0, q_err}, 64'h2);
      repeat (4) @(negedge clk);
      check("t4_skip", {63'd0, busy}, 64'd0);
      cfg(2'd1, 64'h2000, 16'd7, 1'b1);
      check("t4_clr", {60'd0, q_err}, 64'h0);
      repeat (3) @(negedge clk);
      check("t4_empty", {63'd0, busy}, 64'd0);
      db(2'd1, 16'd1);
      wait_init("t4b"); finish_fetch("t4b", 2'd1, 64'h2000, 1'b0, 16'd1);

      // Bad doorbell, then config write to the in-flight queue
      db(2'd3, 16'd9);
      check("t5_qerr", {60'd0, q_err}, 64'h8);
      repeat (3) @(negedge clk);
      check("t5_idle", {63'd0, busy}, 64'd0);
      cfg(2'd3, 64'h4000, 16'd7, 1'b1);
      check("t5_clr", {60'd0, q_err}, 64'h0);
      db(2'd0, 16'd3);
      wait_init("t5a");
      @(negedge clk);
      cfg(2'd0, 64'h9000, 16'd1, 1'b1);
      check("t5_cfgerr", {63'd0, cfg_err}, 64'd1);
      finish_fetch("t5a", 2'd0, 64'h1080, 1'b0, 16'd3);
      check("t5_cfgerr0", {63'd0, cfg_err}, 64'd0);
      db(2'd0, 16'd4);
      wait_init("t5b"); finish_fetch("t5b", 2'd0, 64'h10C0, 1'b0, 16'd4);

      // Asynchronous reset while waiting on a fetch
      db(2'd0, 16'd5);
      wait_init("t6a");
      @(negedge clk);
      check("t6_busy_pre", {63'd0, busy}, 64'd1);
      #2 ARESETN = 1'b0;
      #1;
      check("t6_busy", {63'd0, busy}, 64'd0);
      check("t6_addr", fetch_addr, 64'd0);
      check("t6_init", {63'd0, fetch_init}, 64'd0);
      check("t6_qerr", {60'd0, q_err}, 64'd0);
      @(negedge clk);
      ARESETN = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (fetch_init === 1'b1) seen++;
      end
      check("t6_quiet", 64'(seen), 64'd0);
      check("t6_idle", {63'd0, busy}, 64'd0);
      cfg(2'd0, 64'h5000, 16'd7, 1'b1);
      db(2'd0, 16'd1);
      wait_init("t6b"); finish_fetch("t6b", 2'd0, 64'h5000, 1'b0, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
